// File: rtl/multicycle_main_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_main_fsm
//   Main control FSM of the multicycle RV32I core. Sequences each instruction
//   through fetch / decode / execute / memory / writeback states and drives
//   the ALU select, operand-mux selects and all architectural write enables.
//
//   Optional build macro: MAIN_FSM_ILLEGAL_TRAP_EN
//     defined   : unknown opcode in DECODE enters TRAP (15), which asserts
//                 illegal_instr and holds until reset.
//     undefined : unknown opcode returns to FETCH; illegal_instr tied 0.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   opcode, funct3,
//   funct7b5          : instruction register fields
//   zero              : ALU zero flag (branch resolution)
//   pc_write, ir_write,
//   reg_write,
//   mem_write         : write enables (forced 0 while reset is high)
//   adr_src           : memory address select (0 PC, 1 result)
//   result_src        : result mux (00 ALUOut, 01 read data, 10 ALU result)
//   alu_src_a         : 00 PC, 01 oldPC, 10 rs1, 11 zero
//   alu_src_b         : 00 rs2, 01 immediate, 10 constant 4
//   alu_select        : ALU operation
//   state_dbg         : current state encoding
//   illegal_instr     : TRAP indicator
// ----------------------------------------------------------------------------
module multicycle_main_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_select,
    output logic [3:0] state_dbg,
    output logic       illegal_instr
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRWB   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] w_funct_sel;
    logic [3:0] w_branch_sel;
    logic       w_branch_taken;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arithmetic/logic op decode; SUB only for R-type (I-type has no subi)
    always_comb begin
        w_funct_sel = ALU_ADD;
        case (funct3)
            3'b000:  w_funct_sel = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_funct_sel = ALU_SLL;
            3'b010:  w_funct_sel = ALU_SLT;
            3'b011:  w_funct_sel = ALU_SLTU;
            3'b100:  w_funct_sel = ALU_XOR;
            3'b101:  w_funct_sel = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_funct_sel = ALU_OR;
            3'b111:  w_funct_sel = ALU_AND;
            default: w_funct_sel = ALU_ADD;
        endcase
    end

    // Branch compare op and taken condition (SLT/SLTU result nonzero => less)
    always_comb begin
        w_branch_sel   = ALU_ADD;
        w_branch_taken = 1'b0;
        case (funct3)
            3'b000: begin w_branch_sel = ALU_SUB;  w_branch_taken =  zero; end
            3'b001: begin w_branch_sel = ALU_SUB;  w_branch_taken = !zero; end
            3'b100: begin w_branch_sel = ALU_SLT;  w_branch_taken = !zero; end
            3'b101: begin w_branch_sel = ALU_SLT;  w_branch_taken =  zero; end
            3'b110: begin w_branch_sel = ALU_SLTU; w_branch_taken = !zero; end
            3'b111: begin w_branch_sel = ALU_SLTU; w_branch_taken =  zero; end
            default: begin w_branch_sel = ALU_ADD; w_branch_taken = 1'b0; end
        endcase
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next_state  = S_FETCH;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_select    = ALU_ADD;
        illegal_instr = 1'b0;

        case (r_state)
            S_FETCH: begin
                ir_write     = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_write     = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_R:              w_next_state = S_EXECR;
                    OP_I:              w_next_state = S_EXECI;
                    OP_BR:             w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                    default:           w_next_state = S_TRAP;
`else
                    default:           w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src      = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src   = 2'b01;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b00;
                alu_select   = w_funct_sel;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                alu_select   = w_funct_sel;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 2'b10;
                alu_select   = w_branch_sel;
                pc_write     = w_branch_taken;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write     = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                result_src   = 2'b10;
                pc_write     = 1'b1;
                w_next_state = S_JALRWB;
            end
            S_JALRWB: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_LUI: begin
                alu_src_a    = 2'b11;
                alu_src_b    = 2'b01;
                w_next_state = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b01;
                w_next_state = S_ALUWB;
            end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_instr = 1'b1;
                w_next_state  = S_TRAP;
            end
`endif
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        // No architectural writes while reset is held
        if (reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_main_fsm
//   Directed, table-driven bench for multicycle_main_fsm: one record per clock
//   cycle holding the inputs and the hand-computed outputs for that cycle,
//   followed by per-instruction cycle-count sequences.
// ----------------------------------------------------------------------------
module tb_multicycle_main_fsm;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] sel;
        logic       ill;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        out_t       e;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_select;
    logic [3:0] state_dbg;
    logic       illegal_instr;

    multicycle_main_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .zero         (zero),
        .pc_write     (pc_write),
        .adr_src      (adr_src),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .result_src   (result_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_select   (alu_select),
        .state_dbg    (state_dbg),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t       vecs[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    logic       c_rst;
    logic [6:0] c_op;
    logic [2:0] c_f3;
    logic       c_f7;
    logic       c_z;

    // Select the instruction fields for the following records
    task automatic ir(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        c_op = op; c_f3 = f3; c_f7 = f7; c_z = z; c_rst = 1'b0;
    endtask

    // Append one cycle record: expected state, enables, muxes, ALU op, trap flag
    task automatic ex(input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
                      input logic irw, input logic rw, input logic [1:0] rs, input logic [1:0] a,
                      input logic [1:0] b, input logic [3:0] sel, input logic ill);
        vec_t v;
        v.rst = c_rst; v.op = c_op; v.f3 = c_f3; v.f7 = c_f7; v.z = c_z;
        v.e = '{st: st, pcw: pcw, adr: adr, mw: mw, irw: irw, rw: rw,
                rs: rs, a: a, b: b, sel: sel, ill: ill};
        vecs.push_back(v);
    endtask

    task automatic fetch_v();  ex(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0); endtask
    task automatic decode_v(); ex(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 0); endtask
    task automatic aluwb_v();  ex(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0); endtask

    // Count clock edges from FETCH until FETCH is seen again (bounded)
    task automatic measure(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input int exp_n);
        int n;
        reset = 1'b0; opcode = op; funct3 = f3; funct7b5 = 1'b0; zero = z;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (state_dbg != 4'd0 && n < 20);
        n_vec++;
        if (n != exp_n) begin
            n_fail++;
            $display("FAIL cycles_%s: got %0d cycles, expected %0d", name, n, exp_n);
        end
    endtask

    out_t act;

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;

        // Reset held: FETCH with all enables suppressed
        ir(7'd0, 3'd0, 0, 0); c_rst = 1'b1;
        ex(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0);

        // add, then sub
        ir(OP_R, 3'b000, 0, 0); fetch_v(); decode_v();
        ex(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd0, 0); aluwb_v();
        ir(OP_R, 3'b000, 1, 0); fetch_v(); decode_v();
        ex(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 0); aluwb_v();
        // R-type xor, and
        ir(OP_R, 3'b100, 0, 0); fetch_v(); decode_v();
        ex(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd4, 0); aluwb_v();
        ir(OP_R, 3'b111, 0, 0); fetch_v(); decode_v();
        ex(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd2, 0); aluwb_v();

        // lw, full path
        ir(OP_LOAD, 3'b010, 0, 0); fetch_v(); decode_v();
        ex(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0);
        ex(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0);
        ex(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'd0, 0);

        // lw interrupted by 2-cycle reset in MEMREAD, then rerun
        fetch_v(); decode_v();
        ex(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0);
        c_rst = 1'b1;
        ex(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0);
        ex(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0);
        c_rst = 1'b0;
        fetch_v(); decode_v();
        ex(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0);
        ex(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0);
        ex(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'd0, 0);

        // sw
        ir(OP_STORE, 3'b010, 0, 0); fetch_v(); decode_v();
        ex(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0);
        ex(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0);

        // branches: beq z=1 taken, bne z=1 not, bltu z=0 taken, bge z=1 taken, f3=010 never
        ir(OP_BR, 3'b000, 0, 1); fetch_v(); decode_v();
        ex(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 0);
        ir(OP_BR, 3'b001, 0, 1); fetch_v(); decode_v();
        ex(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 0);
        ir(OP_BR, 3'b110, 0, 0); fetch_v(); decode_v();
        ex(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd6, 0);
        ir(OP_BR, 3'b101, 0, 1); fetch_v(); decode_v();
        ex(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd5, 0);
        ir(OP_BR, 3'b010, 0, 1); fetch_v(); decode_v();
        ex(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd0, 0);

        // I-type: srai, srli, slti, addi with funct7b5=1 (still ADD)
        ir(OP_I, 3'b101, 1, 0); fetch_v(); decode_v();
        ex(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd9, 0); aluwb_v();
        ir(OP_I, 3'b101, 0, 0); fetch_v(); decode_v();
        ex(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd8, 0); aluwb_v();
        ir(OP_I, 3'b010, 0, 0); fetch_v(); decode_v();
        ex(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd5, 0); aluwb_v();
        ir(OP_I, 3'b000, 1, 0); fetch_v(); decode_v();
        ex(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0); aluwb_v();

        // jal, jalr, lui, auipc
        ir(OP_JAL, 3'b000, 0, 0); fetch_v(); decode_v();
        ex(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 0); aluwb_v();
        ir(OP_JALR, 3'b000, 0, 0); fetch_v(); decode_v();
        ex(4'd11, 1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 4'd0, 0);
        ex(4'd12, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 4'd0, 0);
        ir(OP_LUI, 3'b000, 0, 0); fetch_v(); decode_v();
        ex(4'd13, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 4'd0, 0); aluwb_v();
        ir(OP_AUIPC, 3'b000, 0, 0); fetch_v(); decode_v();
        ex(4'd14, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 0); aluwb_v();

        // Unknown opcode
        ir(OP_BAD, 3'b000, 0, 0); fetch_v(); decode_v();
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        repeat (3) ex(4'd15, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1);
        c_rst = 1'b1;
        ex(4'd15, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1);
        ex(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0);
        c_rst = 1'b0;
        fetch_v();
`else
        fetch_v();
`endif

        // Power-on reset: two edges before the table starts
        @(posedge clk); @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            opcode   = vecs[i].op;
            funct3   = vecs[i].f3;
            funct7b5 = vecs[i].f7;
            zero     = vecs[i].z;
            #1;
            act = '{st: state_dbg, pcw: pc_write, adr: adr_src, mw: mem_write,
                    irw: ir_write, rw: reg_write, rs: result_src, a: alu_src_a,
                    b: alu_src_b, sel: alu_select, ill: illegal_instr};
            n_vec++;
            if (act !== vecs[i].e) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b sel=%0d ill=%b, expected st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b sel=%0d ill=%b",
                         i, act.st, act.pcw, act.adr, act.mw, act.irw, act.rw, act.rs, act.a, act.b, act.sel, act.ill,
                         vecs[i].e.st, vecs[i].e.pcw, vecs[i].e.adr, vecs[i].e.mw, vecs[i].e.irw, vecs[i].e.rw,
                         vecs[i].e.rs, vecs[i].e.a, vecs[i].e.b, vecs[i].e.sel, vecs[i].e.ill);
            end
            @(posedge clk); #1;
        end

        // Return to a known FETCH before cycle-count sequences
        reset = 1'b1; opcode = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        measure("load",   OP_LOAD,  3'b010, 0, 5);
        measure("store",  OP_STORE, 3'b010, 0, 4);
        measure("rtype",  OP_R,     3'b000, 0, 4);
        measure("itype",  OP_I,     3'b000, 0, 4);
        measure("branch", OP_BR,    3'b000, 1, 3);
        measure("jal",    OP_JAL,   3'b000, 0, 4);
        measure("jalr",   OP_JALR,  3'b000, 0, 4);
        measure("lui",    OP_LUI,   3'b000, 0, 4);
        measure("auipc",  OP_AUIPC, 3'b000, 0, 4);
`ifndef MAIN_FSM_ILLEGAL_TRAP_EN
        measure("unknown", OP_BAD,  3'b000, 0, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
